exu_seq_ctrl: RTL and testbench
===============================

Name: exu_seq_ctrl

Overview:
Multi-cycle sequencer for the single-issue NPC core. It steps each instruction through FETCH, DECODE, EXEC and WB. It handshakes with the instruction fetch unit, enables decode and execute for one cycle each, captures the EXU write-back triple (wen/waddr/wdata) and drives the register-file write port in WB only. It also owns the PC, halt (ebreak) and fetch-timeout error handling, plus cycle and retired-instruction counters.

Parameters:
ADDR_WIDTH, 5, register-file address width
DATA_WIDTH, 32, datapath, PC and counter width
RESET_PC, 32'h8000_0000, PC value loaded on reset
FETCH_TIMEOUT, 16, max cycles in FETCH without ifu_ready before error (>=2)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
ifu_req  out  1  fetch request; held high for whole FETCH state
ifu_ready  in  1  fetch done; inst_in valid this cycle
inst_in  in  DATA_WIDTH  fetched instruction
inst  out  DATA_WIDTH  latched instruction, stable DECODE..WB
idu_en  out  1  decode enable, high only in DECODE
exu_en  out  1  execute enable, high only in EXEC
halt_req  in  1  decode flags ebreak, sampled in DECODE
exu_wen  in  1  EXU write enable
exu_waddr  in  ADDR_WIDTH  EXU destination register
exu_wdata  in  DATA_WIDTH  EXU result
rf_wen  out  1  register-file write enable
rf_waddr  out  ADDR_WIDTH  register-file write address
rf_wdata  out  DATA_WIDTH  register-file write data
pc  out  DATA_WIDTH  current PC
halted  out  1  sticky halt flag
fetch_err  out  1  sticky fetch-timeout flag
cycle_cnt  out  DATA_WIDTH  running cycle counter
inst_cnt  out  DATA_WIDTH  retired-instruction counter

Behaviour:
- Reset (rst=1 at posedge, any state): state=RESET. pc=RESET_PC. inst, rf_waddr, rf_wdata, cycle_cnt, inst_cnt and the timeout counter =0. halted=0, fetch_err=0. All enables/requests=0. Reset wins over every other event.
- States and transitions: RESET->FETCH unconditionally (one cycle).
- FETCH: ifu_req=1; stays in FETCH while ifu_ready=0.
- FETCH with ifu_ready=1: inst<=inst_in, go to DECODE, timeout counter<=0.
- FETCH timeout: increment the timeout counter each cycle without ready. When the counter reaches FETCH_TIMEOUT-1 and ifu_ready=0, go to ERROR and set fetch_err<=1. A ready on that same cycle wins: go to DECODE.
- DECODE: idu_en=1. halt_req=1 -> HALT, halted<=1; pc and inst_cnt unchanged, no write-back. Otherwise go to EXEC.
- EXEC: exu_en=1. Capture the write-back triple: wb_wen<=exu_wen & (exu_waddr!=0), rf_waddr<=exu_waddr, rf_wdata<=exu_wdata. Go to WB.
- WB: rf_wen=wb_wen, combinational from state, high for exactly this one cycle. pc<=pc+4 (wraps mod 2^DATA_WIDTH). inst_cnt<=inst_cnt+1. Go to FETCH.
- HALT and ERROR are terminal until rst; all enables are 0 and ifu_req=0.
- Latency: 4 cycles per instruction when ifu_ready is asserted in the first FETCH cycle; +1 cycle per wait cycle.
- rf_wen is never high outside WB. Writes to x0 are always suppressed.
- cycle_cnt increments every cycle except in RESET, HALT and ERROR; wraps to 0.
- inst, rf_waddr and rf_wdata hold their values outside their capture cycles.
- ifu_ready outside FETCH is ignored.

Test Plan:
- Reset then ifu_ready=1 each FETCH, inst_in=32'h0010_0093, exu_wen=1, exu_waddr=1, exu_wdata=1 -> rf_wen pulses once 4 cycles after the first ifu_req with waddr=1/wdata=1; pc=0x8000_0004, inst_cnt=1.
- Three back-to-back instructions -> rf_wen high on cycles 4, 8, 12 after reset release+1; pc=0x8000_000C, inst_cnt=3.
- exu_waddr=0, exu_wen=1 -> rf_wen stays 0 in WB; pc and inst_cnt still advance.
- ifu_ready delayed 5 cycles -> ifu_req held 6 cycles, inst latched on the ready cycle. ifu_ready never asserted -> fetch_err=1 after 16 FETCH cycles; ifu_req=0; cycle_cnt frozen.
- halt_req=1 in DECODE of the 2nd instruction -> halted=1, pc=0x8000_0004, inst_cnt=1, no rf_wen. halted and pc stay constant for 20 further cycles.
- rst asserted during EXEC -> next cycle state=RESET, rf_wen=0, pc=0x8000_0000, counters 0. Normal fetch resumes one cycle after rst drops.

Source files
------------

// File: rtl/exu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the single-issue NPC core.
// Owns the PC, the halt/fetch-timeout terminal states, the write-back port and the perf counters.
module exu_seq_ctrl #(
  parameter int unsigned             ADDR_WIDTH    = 5,
  parameter int unsigned             DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0]   RESET_PC      = DATA_WIDTH'(32'h8000_0000),
  parameter int unsigned             FETCH_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req,
  input  logic                  ifu_ready,
  input  logic [DATA_WIDTH-1:0] inst_in,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  idu_en,
  output logic                  exu_en,
  input  logic                  halt_req,
  input  logic                  exu_wen,
  input  logic [ADDR_WIDTH-1:0] exu_waddr,
  input  logic [DATA_WIDTH-1:0] exu_wdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  halted,
  output logic                  fetch_err,
  output logic [DATA_WIDTH-1:0] cycle_cnt,
  output logic [DATA_WIDTH-1:0] inst_cnt
);

  localparam int unsigned     TMO_W    = $clog2(FETCH_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT,
    S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic                  wb_wen_q, wb_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  halted_q, halted_d;
  logic                  fetch_err_q, fetch_err_d;
  logic [DATA_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [DATA_WIDTH-1:0] inst_cnt_q, inst_cnt_d;
  logic                  ifu_req_q, ifu_req_d;
  logic                  idu_en_q, idu_en_d;
  logic                  exu_en_q, exu_en_d;
  logic                  rf_wen_q, rf_wen_d;

  // Next-state, datapath captures and one-hot enables decoded from the next state.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    inst_d      = inst_q;
    wb_wen_d    = wb_wen_q;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    pc_d        = pc_q;
    halted_d    = halted_q;
    fetch_err_d = fetch_err_q;
    cycle_cnt_d = cycle_cnt_q;
    inst_cnt_d  = inst_cnt_q;

    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (ifu_ready) begin
          inst_d  = inst_in;
          tmo_d   = '0;
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          fetch_err_d = 1'b1;
          state_d     = S_ERROR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DECODE: begin
        if (halt_req) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        wb_wen_d   = exu_wen & (exu_waddr != '0);
        rf_waddr_d = exu_waddr;
        rf_wdata_d = exu_wdata;
        state_d    = S_WB;
      end
      S_WB: begin
        pc_d       = pc_q + DATA_WIDTH'(4);
        inst_cnt_d = inst_cnt_q + DATA_WIDTH'(1);
        state_d    = S_FETCH;
      end
      default: state_d = state_q;
    endcase

    if (state_q inside {S_FETCH, S_DECODE, S_EXEC, S_WB}) begin
      cycle_cnt_d = cycle_cnt_q + DATA_WIDTH'(1);
    end

    ifu_req_d = (state_d == S_FETCH);
    idu_en_d  = (state_d == S_DECODE);
    exu_en_d  = (state_d == S_EXEC);
    rf_wen_d  = (state_d == S_WB) & wb_wen_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RESET;
      tmo_q       <= '0;
      inst_q      <= '0;
      wb_wen_q    <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      pc_q        <= RESET_PC;
      halted_q    <= 1'b0;
      fetch_err_q <= 1'b0;
      cycle_cnt_q <= '0;
      inst_cnt_q  <= '0;
      ifu_req_q   <= 1'b0;
      idu_en_q    <= 1'b0;
      exu_en_q    <= 1'b0;
      rf_wen_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      inst_q      <= inst_d;
      wb_wen_q    <= wb_wen_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      pc_q        <= pc_d;
      halted_q    <= halted_d;
      fetch_err_q <= fetch_err_d;
      cycle_cnt_q <= cycle_cnt_d;
      inst_cnt_q  <= inst_cnt_d;
      ifu_req_q   <= ifu_req_d;
      idu_en_q    <= idu_en_d;
      exu_en_q    <= exu_en_d;
      rf_wen_q    <= rf_wen_d;
    end
  end

  assign ifu_req   = ifu_req_q;
  assign idu_en    = idu_en_q;
  assign exu_en    = exu_en_q;
  assign inst      = inst_q;
  assign rf_wen    = rf_wen_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign pc        = pc_q;
  assign halted    = halted_q;
  assign fetch_err = fetch_err_q;
  assign cycle_cnt = cycle_cnt_q;
  assign inst_cnt  = inst_cnt_q;

endmodule

// File: tb/tb_exu_seq_ctrl.sv
// Directed bench for exu_seq_ctrl; write-backs are checked against a queue scoreboard.
module tb_exu_seq_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req;
  logic        ifu_ready;
  logic [31:0] inst_in;
  logic [31:0] inst;
  logic        idu_en;
  logic        exu_en;
  logic        halt_req;
  logic        exu_wen;
  logic [4:0]  exu_waddr;
  logic [31:0] exu_wdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pc;
  logic        halted;
  logic        fetch_err;
  logic [31:0] cycle_cnt;
  logic [31:0] inst_cnt;

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  logic [4:0]  sb_addr[$];
  logic [31:0] sb_data[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_icnt;
  logic [31:0] exp_cyc;
  logic [31:0] frz;

  exu_seq_ctrl dut (
    .clk(clk), .rst(rst), .ifu_req(ifu_req), .ifu_ready(ifu_ready), .inst_in(inst_in),
    .inst(inst), .idu_en(idu_en), .exu_en(exu_en), .halt_req(halt_req),
    .exu_wen(exu_wen), .exu_waddr(exu_waddr), .exu_wdata(exu_wdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc(pc),
    .halted(halted), .fetch_err(fetch_err), .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every register-file write must match the oldest expected write-back.
  always @(negedge clk) begin
    if (rf_wen !== 1'b0) begin
      if (sb_addr.size() == 0) begin
        chk("rf_wen_unexpected", 64'(rf_wen), 64'd0);
      end else begin
        chk("sb_waddr", 64'(rf_waddr), 64'(sb_addr.pop_front()));
        chk("sb_wdata", 64'(rf_wdata), 64'(sb_data.pop_front()));
      end
    end
  end

  // Runs one instruction starting in FETCH; waits = cycles before ifu_ready.
  task automatic run_inst(input logic [31:0] iv, input int waits, input logic wen,
                          input logic [4:0] wa, input logic [31:0] wd, input logic hlt);
    for (int i = 0; i < waits; i++) begin
      chk("ifu_req_wait", 64'(ifu_req), 64'd1);
      step();
      exp_cyc++;
    end
    chk("ifu_req", 64'(ifu_req), 64'd1);
    ifu_ready = 1'b1;
    inst_in   = iv;
    step();
    exp_cyc++;
    ifu_ready = 1'b0;
    inst_in   = $urandom;
    chk("idu_en", 64'(idu_en), 64'd1);
    chk("inst_latch", 64'(inst), 64'(iv));
    chk("ifu_req_dec", 64'(ifu_req), 64'd0);
    halt_req = hlt;
    step();
    exp_cyc++;
    halt_req = 1'b0;
    if (hlt) begin
      chk("halted", 64'(halted), 64'd1);
      chk("halt_pc", 64'(pc), 64'(exp_pc));
      chk("halt_icnt", 64'(inst_cnt), 64'(exp_icnt));
      chk("halt_cyc", 64'(cycle_cnt), 64'(exp_cyc));
      return;
    end
    chk("exu_en", 64'(exu_en), 64'd1);
    chk("idu_en_off", 64'(idu_en), 64'd0);
    exu_wen   = wen;
    exu_waddr = wa;
    exu_wdata = wd;
    if (wen && wa != 5'd0) begin
      sb_addr.push_back(wa);
      sb_data.push_back(wd);
    end
    step();
    exp_cyc++;
    exu_wen   = $urandom_range(0, 1);
    exu_waddr = $urandom;
    exu_wdata = $urandom;
    chk("wb_rf_wen", 64'(rf_wen), 64'(wen && wa != 5'd0));
    chk("wb_waddr", 64'(rf_waddr), 64'(wa));
    chk("wb_exu_en_off", 64'(exu_en), 64'd0);
    step();
    exp_cyc++;
    exp_pc   = exp_pc + 32'd4;
    exp_icnt = exp_icnt + 32'd1;
    chk("pc", 64'(pc), 64'(exp_pc));
    chk("inst_cnt", 64'(inst_cnt), 64'(exp_icnt));
    chk("cycle_cnt", 64'(cycle_cnt), 64'(exp_cyc));
    chk("rf_wen_fetch", 64'(rf_wen), 64'd0);
    chk("inst_hold", 64'(inst), 64'(iv));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    chk("rst_pc", 64'(pc), 64'(RST_PC));
    chk("rst_cyc", 64'(cycle_cnt), 64'd0);
    chk("rst_icnt", 64'(inst_cnt), 64'd0);
    chk("rst_flags", 64'({halted, fetch_err, ifu_req, idu_en, exu_en, rf_wen}), 64'd0);
    rst = 1'b0;
    step();
    exp_pc   = RST_PC;
    exp_icnt = 32'd0;
    exp_cyc  = 32'd0;
  endtask

  initial begin
    rst       = 1'b1;
    ifu_ready = 1'b0;
    inst_in   = '0;
    halt_req  = 1'b0;
    exu_wen   = 1'b0;
    exu_waddr = '0;
    exu_wdata = '0;
    do_reset();
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);

    // Single instruction, then two more back-to-back.
    run_inst(32'h0010_0093, 0, 1'b1, 5'd1, 32'd1, 1'b0);
    run_inst(32'h0020_0113, 0, 1'b1, 5'd2, 32'hdead_beef, 1'b0);
    run_inst(32'h0030_0193, 0, 1'b1, 5'd31, 32'h1234_5678, 1'b0);
    chk("pc_three", 64'(pc), 64'h8000_000C);

    // x0 write suppressed, wen=0 suppressed, delayed fetch, and ready on the last timeout cycle.
    run_inst(32'h0000_0013, 0, 1'b1, 5'd0, 32'hffff_ffff, 1'b0);
    run_inst(32'h0040_0213, 0, 1'b0, 5'd4, 32'h4444_4444, 1'b0);
    run_inst(32'h0050_0293, 5, 1'b1, 5'd5, 32'h5555_5555, 1'b0);
    run_inst(32'h0060_0313, 15, 1'b1, 5'd6, 32'h6666_6666, 1'b0);
    chk("fetch_err_clear", 64'(fetch_err), 64'd0);

    // Halt on the second instruction.
    do_reset();
    run_inst(32'h0010_0093, 0, 1'b1, 5'd1, 32'd1, 1'b0);
    run_inst(32'h0010_0073, 0, 1'b1, 5'd7, 32'd7, 1'b1);
    chk("halt_pc_abs", 64'(pc), 64'h8000_0004);
    frz = cycle_cnt;
    ifu_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("halt_hold", 64'({halted, ifu_req, idu_en, exu_en, rf_wen}), 64'b10000);
      chk("halt_pc_hold", 64'(pc), 64'h8000_0004);
      chk("halt_cyc_hold", 64'(cycle_cnt), 64'(frz));
    end
    ifu_ready = 1'b0;

    // Fetch never completes: 16 FETCH cycles then ERROR.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk("tmo_req", 64'(ifu_req), 64'd1);
      chk("tmo_err_low", 64'(fetch_err), 64'd0);
      step();
    end
    chk("tmo_err", 64'(fetch_err), 64'd1);
    chk("tmo_req_off", 64'(ifu_req), 64'd0);
    chk("tmo_cyc", 64'(cycle_cnt), 64'd16);
    ifu_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    ifu_ready = 1'b0;
    chk("tmo_cyc_frozen", 64'(cycle_cnt), 64'd16);
    chk("tmo_terminal", 64'({fetch_err, ifu_req, idu_en}), 64'b100);

    // Reset asserted while in EXEC, then normal operation resumes.
    do_reset();
    run_inst(32'h0010_0093, 0, 1'b1, 5'd1, 32'd1, 1'b0);
    ifu_ready = 1'b1;
    inst_in   = 32'h0070_0393;
    step();
    ifu_ready = 1'b0;
    step();
    chk("pre_rst_exec", 64'(exu_en), 64'd1);
    exu_wen   = 1'b1;
    exu_waddr = 5'd9;
    exu_wdata = 32'h9999_9999;
    rst = 1'b1;
    step();
    chk("mid_rst_rf_wen", 64'(rf_wen), 64'd0);
    chk("mid_rst_pc", 64'(pc), 64'(RST_PC));
    chk("mid_rst_cnt", 64'({cycle_cnt, inst_cnt}), 64'd0);
    chk("mid_rst_en", 64'({ifu_req, idu_en, exu_en}), 64'd0);
    rst = 1'b0;
    exu_wen = 1'b0;
    step();
    exp_pc   = RST_PC;
    exp_icnt = 32'd0;
    exp_cyc  = 32'd0;
    run_inst(32'h00a0_0513, 2, 1'b1, 5'd10, 32'haaaa_0000, 1'b0);

    step();
    chk("sb_drained", 64'(sb_addr.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
